// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word per request from
// instruction memory, and hands it to decode through a valid/ready IF/ID register.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_next,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  output logic [63:0] pc_out,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  output logic        fetch_err
);

  // Handshakes: imem completes a read in the cycle imem_ack is high while
  // imem_req is high; an instruction moves to decode on the rising edge where
  // inst_valid and inst_ready are both high. flush overrides both.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam logic [7:0] ERR_CNT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        err_q, err_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  wait_cnt_inc;

  assign wait_cnt_inc = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    err_d        = err_q;
    wait_cnt_d   = wait_cnt_q;
    if (flush) begin
      // Any ack this cycle is dropped; IDLE withdraws the old request for a cycle.
      inst_valid_d = 1'b0;
      pc_d         = {flush_pc[63:2], 2'b00};
      state_d      = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd0;
        end
        ST_WAIT: begin
          if (imem_ack) begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = {pc_next[63:2], 2'b00};
            state_d      = ST_FULL;
          end else begin
            wait_cnt_d = wait_cnt_inc;
            if (wait_cnt_inc >= ERR_CNT) err_d = 1'b1;
          end
        end
        ST_FULL: begin
          if (inst_ready) begin
            inst_valid_d = 1'b0;
            state_d      = ST_WAIT;
            wait_cnt_d   = 8'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= {RESET_PC[63:2], 2'b00};
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 64'd0;
      err_q        <= 1'b0;
      wait_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      err_q        <= err_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign pc_out     = pc_q;
  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == ST_WAIT);
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: imem responder, PC model with expected-instruction
// queue, and one task per scenario.
module tb_fetch_stage;

  localparam logic [63:0] RST_PC     = 64'd0;
  localparam int          TB_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] pc_next;
  logic        flush = 1'b0;
  logic [63:0] flush_pc = 64'd0;
  logic [63:0] pc_out;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  logic        mem_on = 1'b0;
  logic        branch_en = 1'b0;
  int          req_age = 0;
  logic [31:0] last_rdata = 32'd0;
  logic [63:0] model_pc = RST_PC;
  logic        seen_branch = 1'b0;
  logic [95:0] exp_q[$];
  logic [95:0] exp_w;

  fetch_stage #(.RESET_PC(RST_PC), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .flush(flush), .flush_pc(flush_pc),
    .pc_out(pc_out), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // PC calculator: PC+4, or a taken branch to 0x40 from PC 8 when enabled.
  assign pc_next = (branch_en && pc_out == 64'h8) ? 64'h40 : pc_out + 64'd4;

  // imem responder: acks in the second cycle of each request with random data.
  always @(posedge clk) begin
    #1;
    if (mem_on) begin
      imem_ack = 1'b0;
      if (imem_req === 1'b1) begin
        if (req_age >= 1) begin
          imem_ack   = 1'b1;
          imem_rdata = $urandom;
          last_rdata = imem_rdata;
          req_age    = 0;
        end else begin
          req_age++;
        end
      end else begin
        req_age = 0;
      end
    end else begin
      req_age = 0;
    end
  end

  // Scoreboard: PC model, request address check, expected-instruction queue.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_pc = {RST_PC[63:2], 2'b00};
    end else if (flush) begin
      exp_q.delete();
      model_pc = {flush_pc[63:2], 2'b00};
    end else begin
      if (imem_req === 1'b1) begin
        checks++;
        if (imem_addr !== model_pc) begin
          errors++;
          $display("FAIL imem_addr got %h exp %h", imem_addr, model_pc);
        end
      end
      if (inst_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL inst_unexpected got pc %h inst %h exp none", inst_pc, inst_out);
        end else begin
          exp_w = exp_q[0];
          if ({inst_pc, inst_out} !== exp_w) begin
            errors++;
            $display("FAIL inst_data got pc %h inst %h exp pc %h inst %h",
                     inst_pc, inst_out, exp_w[95:32], exp_w[31:0]);
          end
          if (inst_ready === 1'b1) begin
            exp_w = exp_q.pop_front();
            if (exp_w[95:32] == 64'h40) seen_branch = 1'b1;
          end
        end
      end
      if (imem_ack === 1'b1) begin
        exp_q.push_back({model_pc, imem_rdata});
        model_pc = (branch_en && model_pc == 64'h8) ? 64'h40 : model_pc + 64'd4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    mem_on     = 1'b0;
    imem_ack   = 1'b0;
    flush      = 1'b0;
    inst_ready = 1'b0;
    branch_en  = 1'b0;
    reset      = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (inst_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (inst_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s wait_valid got timeout exp valid within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_req(input int budget, input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (imem_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s wait_req got timeout exp req within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks += 6;
    if (pc_out !== 64'd0)    begin errors++; $display("FAIL rst_pc got %h exp 0", pc_out); end
    if (imem_req !== 1'b0)   begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
    if (inst_out !== 32'd0)  begin errors++; $display("FAIL rst_inst got %h exp 0", inst_out); end
    if (inst_pc !== 64'd0)   begin errors++; $display("FAIL rst_inst_pc got %h exp 0", inst_pc); end
    if (fetch_err !== 1'b0)  begin errors++; $display("FAIL rst_err got %b exp 0", fetch_err); end
    mem_on = 1'b1;
    inst_ready = 1'b1;
    reset = 1'b0;
    checks += 2;
    if (imem_req !== 1'b0)   begin errors++; $display("FAIL bubble_req got %b exp 0", imem_req); end
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b exp 0", inst_valid); end
    step();
    checks += 3;
    if (imem_req !== 1'b1)   begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
    if (imem_addr !== 64'd0) begin errors++; $display("FAIL first_addr got %h exp 0", imem_addr); end
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL early_valid got %b exp 0", inst_valid); end
  endtask

  task automatic test_stream_branch();
    apply_reset();
    mem_on = 1'b1;
    branch_en = 1'b1;
    seen_branch = 1'b0;
    for (int i = 0; i < 60; i++) begin
      inst_ready = (i < 12) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
    end
    checks++;
    if (seen_branch !== 1'b1) begin
      errors++;
      $display("FAIL branch_target got seen=%b exp seen=1 (inst_pc 0x40)", seen_branch);
    end
    branch_en = 1'b0;
  endtask

  task automatic test_stall();
    apply_reset();
    mem_on = 1'b1;
    inst_ready = 1'b0;
    wait_valid(10, "stall");
    for (int i = 0; i < 5; i++) begin
      checks += 4;
      if (imem_req !== 1'b0)      begin errors++; $display("FAIL stall_req got %b exp 0", imem_req); end
      if (pc_out !== 64'd4)       begin errors++; $display("FAIL stall_pc got %h exp 4", pc_out); end
      if (inst_pc !== 64'd0)      begin errors++; $display("FAIL stall_inst_pc got %h exp 0", inst_pc); end
      if (inst_out !== last_rdata) begin errors++; $display("FAIL stall_inst got %h exp %h", inst_out, last_rdata); end
      step();
    end
    inst_ready = 1'b1;
    step();
    checks += 3;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL handoff_valid got %b exp 0", inst_valid); end
    if (imem_req !== 1'b1)   begin errors++; $display("FAIL resume_req got %b exp 1", imem_req); end
    if (imem_addr !== 64'd4) begin errors++; $display("FAIL resume_addr got %h exp 4", imem_addr); end
  endtask

  task automatic test_flush();
    apply_reset();
    inst_ready = 1'b1;
    wait_req(10, "flush");
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    flush      = 1'b1;
    flush_pc   = 64'h1003;
    step();
    imem_ack = 1'b0;
    flush    = 1'b0;
    checks += 3;
    if (inst_valid !== 1'b0)     begin errors++; $display("FAIL flush_valid got %b exp 0", inst_valid); end
    if (imem_req !== 1'b0)       begin errors++; $display("FAIL flush_bubble got %b exp 0", imem_req); end
    if (pc_out !== 64'h1000)     begin errors++; $display("FAIL flush_pc got %h exp 1000", pc_out); end
    step();
    checks += 2;
    if (imem_req !== 1'b1)       begin errors++; $display("FAIL flush_req got %b exp 1", imem_req); end
    if (imem_addr !== 64'h1000)  begin errors++; $display("FAIL flush_addr got %h exp 1000", imem_addr); end
    mem_on = 1'b1;
    wait_valid(10, "flush_refetch");
    checks++;
    if (inst_pc !== 64'h1000)    begin errors++; $display("FAIL flush_inst_pc got %h exp 1000", inst_pc); end
    step();
  endtask

  task automatic test_timeout();
    apply_reset();
    inst_ready = 1'b0;
    step();
    for (int k = 1; k <= 16; k++) begin
      checks += 2;
      if (imem_req !== 1'b1) begin errors++; $display("FAIL to_req cycle %0d got %b exp 1", k, imem_req); end
      if (fetch_err !== (k == 16)) begin
        errors++;
        $display("FAIL to_err cycle %0d got %b exp %b", k, fetch_err, (k == 16));
      end
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    checks += 2;
    if (fetch_err !== 1'b1)  begin errors++; $display("FAIL to_sticky got %b exp 1", fetch_err); end
    if (inst_valid !== 1'b1) begin errors++; $display("FAIL to_late_valid got %b exp 1", inst_valid); end
    inst_ready = 1'b1;
    step();
    checks++;
    if (fetch_err !== 1'b1)  begin errors++; $display("FAIL to_sticky2 got %b exp 1", fetch_err); end
    apply_reset();
    checks++;
    if (fetch_err !== 1'b0)  begin errors++; $display("FAIL to_clear got %b exp 0", fetch_err); end
  endtask

  task automatic test_reset_full();
    apply_reset();
    mem_on = 1'b1;
    inst_ready = 1'b0;
    wait_valid(10, "reset_full");
    reset = 1'b1;
    step();
    checks += 3;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL rf_valid got %b exp 0", inst_valid); end
    if (pc_out !== RST_PC)   begin errors++; $display("FAIL rf_pc got %h exp %h", pc_out, RST_PC); end
    if (imem_req !== 1'b0)   begin errors++; $display("FAIL rf_req got %b exp 0", imem_req); end
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_stream_branch();
    test_stall();
    test_flush();
    test_timeout();
    test_reset_full();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
